wb_unit_result_buffer: RTL

- Unit-side producer for the writeback unit interface (done/id/rd out, ack in).
- Sits between a functional unit's result stage and the writeback arbiter.
- Queues completed results in a small FIFO and presents the oldest one to writeback.
- Decouples the unit pipeline from arbitration stalls, so a unit can keep issuing while writeback serves other units.

---
 rtl/wb_unit_result_buffer.sv | 118 +++++++++++
 1 files changed

// File: rtl/wb_unit_result_buffer.sv
// -----------------------------------------------------------------------------
// wb_unit_result_buffer
//
// Unit-side result queue that feeds the writeback arbiter. A functional unit
// pushes completed results {id, rd} and the oldest queued result is presented
// to writeback on wb_done/wb_id/wb_rd until it is acknowledged. The unit can
// therefore keep completing work while writeback is busy with other units.
//
// Ports:
//   clk        core clock
//   rst        asynchronous reset, active-low
//   in_valid   unit presents a completed result
//   in_ready   buffer can accept a result this cycle
//   in_id      instruction ID of the incoming result
//   in_rd      incoming result data
//   wb_done    head result available to writeback
//   wb_id      head instruction ID (0 when empty)
//   wb_rd      head result data (0 when empty)
//   wb_ack     writeback accepted the head this cycle
//   count      current occupancy (0..DEPTH)
//   proto_err  sticky protocol-violation flag, cleared only by reset
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge where the producer's valid
//   (in_valid / wb_done) and the consumer's ready (in_ready / wb_ack) are both
//   high. in_ready and wb_done come from registered state only, so neither has
//   a combinational dependency on in_* or wb_ack. Asserting in_valid while
//   in_ready is low, or wb_ack while wb_done is low, is a protocol violation:
//   the event is dropped and proto_err latches high.
// -----------------------------------------------------------------------------
module wb_unit_result_buffer #(
  parameter int DEPTH      = 4,   // power of two, minimum 2
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4    // LOG2_MAX_IDS of the core's id_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ID_WIDTH-1:0]      in_id,
  input  logic [DATA_WIDTH-1:0]    in_rd,
  output logic                     wb_done,
  output logic [ID_WIDTH-1:0]      wb_id,
  output logic [DATA_WIDTH-1:0]    wb_rd,
  input  logic                     wb_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] rd;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head_entry;
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [CW-1:0]   count_q;
  logic            proto_err_q;

  logic            push;
  logic            pop;
  logic            bad_push;
  logic            bad_ack;

  // Flow control and head visibility are pure functions of the occupancy
  // register; this is what keeps wb_ack out of in_ready's cone and in_* out
  // of the wb_* cone.
  assign in_ready = (count_q != FULL_CNT);
  assign wb_done  = (count_q != '0);

  assign push     = in_valid & in_ready;
  assign pop      = wb_ack & wb_done;
  assign bad_push = in_valid & ~in_ready;
  assign bad_ack  = wb_ack & ~wb_done;

  // Pointers and occupancy. Pointers are exactly PW bits wide, so with a
  // power-of-two DEPTH the increment wraps DEPTH-1 -> 0 on its own; count
  // tells full apart from empty when the pointers coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (bad_push || bad_ack) proto_err_q <= 1'b1;
    end
  end

  // Storage needs no reset: an entry is only ever observed while count says
  // it is live, and reset clears count.
  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= '{id: in_id, rd: in_rd};
  end

  assign head_entry = mem[head_q];

  // Zero the bus when empty so stale entries never leak out, including the
  // instant an asynchronous reset clears count.
  assign wb_id     = wb_done ? head_entry.id : '0;
  assign wb_rd     = wb_done ? head_entry.rd : '0;
  assign count     = count_q;
  assign proto_err = proto_err_q;

endmodule
